// File: rtl/seq_mult_param.sv
// seq_mult_param
//   Sequential shift-add multiplier, one partial-product step per clock.
//   Handles unsigned or two's-complement operands, chosen per operation.
//   Operands and mode are captured when start is accepted. The product
//   register holds its value until the next operation completes.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-high; clears all state
//   start    request; only sampled in IDLE
//   tc       1 = two's-complement operands, 0 = unsigned (captured with start)
//   mcand    multiplicand (captured with start)
//   mplier   multiplier (captured with start)
//   busy     high in RUN and DONE
//   done     one-cycle pulse; product is valid
//   product  2*WIDTH-bit result register
//
// state | meaning
// IDLE  | waiting for start
// RUN   | WIDTH shift-add steps, one per clock
// DONE  | product just updated, done pulse, back to IDLE next clock
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand_r;
  logic               tc_r;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;

  logic               last;
  logic [WIDTH:0]     hi_x;
  logic [WIDTH:0]     mc_x;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_nxt;

  // The add is done at W+1 bits. Sign-extend in signed mode and
  // zero-extend in unsigned mode. The extra bit becomes the new
  // accumulator MSB: it is the carry for unsigned operands and the
  // sign for signed operands. Negating the most-negative multiplicand
  // is exact at W+1 bits.
  always_comb begin
    last    = (count == CW'(WIDTH - 1));
    hi_x    = {tc_r & acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
    mc_x    = {tc_r & mcand_r[WIDTH-1], mcand_r};
    addend  = '0;
    if (acc[0]) begin
      // In signed mode the multiplier sign bit has negative weight.
      addend = (tc_r && last) ? -mc_x : mc_x;
    end
    sum     = hi_x + addend;
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mcand_r <= '0;
      tc_r    <= 1'b0;
      acc     <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand_r <= mcand;
            tc_r    <= tc;
            acc     <= {{WIDTH{1'b0}}, mplier};
            count   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          count <= count + CW'(1);
          if (last) begin
            product <= acc_nxt;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start8 = 1'b0, tc8 = 1'b0;
  logic [7:0]  mc8 = '0, mp8 = '0;
  logic        busy8, done8;
  logic [15:0] product8;

  logic        start16 = 1'b0, tc16 = 1'b0;
  logic [15:0] mc16 = '0, mp16 = '0;
  logic        busy16, done16;
  logic [31:0] product16;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev8 = '0;
  logic [31:0] prev16 = '0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .tc(tc8),
    .mcand(mc8), .mplier(mp8), .busy(busy8), .done(done8), .product(product8)
  );

  seq_mult_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .tc(tc16),
    .mcand(mc16), .mplier(mp16), .busy(busy16), .done(done16), .product(product16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One W=8 operation. Inputs are scrambled right after capture.
  // The task checks the latency, the busy length, that the product is held
  // during RUN, the result itself and the return to idle.
  task automatic op8(input logic t, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input string tag);
    int lat, bcnt;
    logic held_ok;
    @(negedge clk);
    tc8 = t; mc8 = a; mp8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; tc8 = ~t; mc8 = ~a; mp8 = ~b;
    lat = 0; bcnt = int'(busy8); held_ok = 1'b1;
    while (!done8 && lat < 40) begin
      if (product8 !== prev8) held_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      bcnt += int'(busy8);
    end
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_hold"}, {31'd0, held_ok}, 32'd1);
    chk(tag, product8, exp);
    @(posedge clk); #1;
    bcnt += int'(busy8);
    chk({tag, "_busy9"}, bcnt, 9);
    chk({tag, "_done_off"}, {31'd0, done8}, 32'd0);
    prev8 = exp;
  endtask

  task automatic op16(input logic t, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp, input string tag);
    int lat;
    @(negedge clk);
    tc16 = t; mc16 = a; mp16 = b; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; mc16 = ~a; mp16 = ~b;
    lat = 0;
    while (!done16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 16);
    chk(tag, product16, exp);
    prev16 = exp;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] model16(input logic t, input logic [15:0] a, input logic [15:0] b);
    longint pa, pb;
    pa = t ? longint'($signed(a)) : longint'(a);
    pb = t ? longint'($signed(b)) : longint'(b);
    return 32'(pa * pb);
  endfunction

  initial begin
    int ndone, first_e, second_e;
    logic [15:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_prod8", {16'd0, product8}, 32'd0);
    chk("rst_prod16", product16, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Unsigned and signed directed vectors at W=8.
    op8(1'b0, 8'hA0, 8'hD4, 16'h8480, "u_a0d4");
    op8(1'b1, 8'hA0, 8'hD4, 16'h1080, "s_a0d4");
    op8(1'b1, 8'hFF, 8'hFF, 16'h0001, "s_ffff");
    op8(1'b1, 8'h80, 8'h01, 16'hFF80, "s_8001");
    op8(1'b1, 8'h80, 8'h80, 16'h4000, "s_8080");
    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ffff");
    op8(1'b0, 8'h00, 8'h5A, 16'h0000, "u_00xx");
    op8(1'b1, 8'h7F, 8'h80, 16'hC080, "s_7f80");

    // Start held high: a new operation every 10 clocks.
    @(negedge clk);
    tc8 = 1'b0; mc8 = 8'h03; mp8 = 8'h05; start8 = 1'b1;
    ndone = 0; first_e = -1; second_e = -1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        if (first_e < 0) first_e = i;
        else if (second_e < 0) second_e = i;
      end
    end
    start8 = 1'b0;
    chk("b2b_count", ndone, 3);
    chk("b2b_period", second_e - first_e, 10);
    chk("b2b_prod", product8, 16'h000F);
    repeat (3) @(posedge clk);
    #1;
    prev8 = 16'h000F;

    // A start pulse during RUN step 3 is ignored.
    @(negedge clk);
    tc8 = 1'b0; mc8 = 8'hA0; mp8 = 8'hD4; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mc8 = 8'h01; mp8 = 8'h01; tc8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    chk("ign_done_cnt", ndone, 1);
    chk("ign_prod", product8, 16'h8480);
    chk("ign_idle", {31'd0, busy8}, 32'd0);
    prev8 = 16'h8480;

    // Reset asserted between edges during RUN step 4.
    @(negedge clk);
    tc8 = 1'b0; mc8 = 8'h11; mp8 = 8'h22; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_prod", product8, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    prev8 = 16'h0000;
    prev16 = '0;
    op8(1'b0, 8'h0C, 8'h0D, 16'h009C, "post_rst");

    // W=16 directed vectors.
    op16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "u16_ffff");
    op16(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, "s16_8000");
    op16(1'b1, 16'h8000, 16'h8000, 32'h40000000, "s16_mm");

    // Random W=16 sweep in both modes against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      op16(i[0], ra, rb, model16(i[0], ra, rb), "rnd16");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
